// File: rtl/jtframe_palmix.sv
// jtframe_palmix: layer priority mixer with a dual-ported palette RAM.
// Picks the highest-priority opaque layer at each pixel, fetches its 16-bit
// colour word over two clk through a video byte port, and presents the colour
// on red/green/blue with a fixed one-pixel latency. Blanking is delayed to match.
//
// Optional feature: define JTFRAME_PALMIX_DIM_EN to scale every channel by
// (bright+1)/16; without it bright is ignored.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   pxl_cen             pixel clock enable (one clk wide, >= 4 clk apart)
//   LHBL, LVBL          horizontal / vertical blank, active-low
//   lyr_pxl, lyr_en     per-layer palette indices (layer 0 = LSBs, top priority)
//   pal_bank            palette bank, shared by CPU and video addressing
//   pal_cs, wr_n        CPU chip select and active-low write strobe
//   cpu_addr, cpu_dout  CPU byte address (bit 0 = byte lane) and write data
//   pal_dout            CPU read data, one clk after the address
//   bright              global brightness (dimming builds only)
//   red, green, blue    final colour, CW bits each
module jtframe_palmix #(
  parameter int unsigned LAYERS = 2,
  parameter int unsigned PXLW   = 11,
  parameter int unsigned CW     = 4,
  parameter logic [3:0]  TRANSP = 4'hF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pxl_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  input  logic [LAYERS*PXLW-1:0] lyr_pxl,
  input  logic [LAYERS-1:0]      lyr_en,
  input  logic                   pal_bank,
  input  logic                   pal_cs,
  input  logic                   wr_n,
  input  logic [PXLW:0]          cpu_addr,
  input  logic [7:0]             cpu_dout,
  output logic [7:0]             pal_dout,
  input  logic [3:0]             bright,
  output logic [CW-1:0]          red,
  output logic [CW-1:0]          green,
  output logic [CW-1:0]          blue
);

  localparam int unsigned AW    = PXLW + 1;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned PW    = CW + 5;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD_LO = 2'd1;
  localparam logic [1:0] RD_HI = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [7:0]      ram_lo [0:DEPTH-1];
  logic [7:0]      ram_hi [0:DEPTH-1];

  logic [AW-1:0]   cpu_a;
  logic [AW-1:0]   vid_a;
  logic [1:0]      state;
  logic [1:0]      state_nx;
  logic [PXLW-1:0] pick_c;
  logic [7:0]      vid_q;
  logic [7:0]      lo_byte;
  logic [15:0]     word_c;
  logic [CW-1:0]   fresh_r_c, fresh_g_c, fresh_b_c;
  logic [CW-1:0]   show_r_c, show_g_c, show_b_c;
  logic [CW-1:0]   pix_r, pix_g, pix_b;
  logic            lhbl_d;
  logic            lvbl_d;

`ifdef JTFRAME_PALMIX_DIM_EN
  // Scale a channel by (lvl+1)/16, truncating.
  function automatic logic [CW-1:0] dim(input logic [CW-1:0] c, input logic [3:0] lvl);
    logic [PW-1:0] prod;
    prod = PW'(c) * PW'({1'b0, lvl} + 5'd1);
    return CW'(prod >> 4);
  endfunction
`else
  function automatic logic [CW-1:0] dim(input logic [CW-1:0] c);
    return c;
  endfunction

  logic bright_unused;
  assign bright_unused = ^bright;
`endif

  assign cpu_a = {pal_bank, cpu_addr[PXLW:1]};

  // Lowest-numbered enabled, opaque layer wins; backdrop index 0 otherwise.
  always_comb begin
    pick_c = '0;
    for (int i = int'(LAYERS) - 1; i >= 0; i--) begin
      if (lyr_en[i] && (lyr_pxl[i*PXLW +: 4] != TRANSP)) begin
        pick_c = lyr_pxl[i*PXLW +: PXLW];
      end
    end
  end

  // Palette RAM: CPU read/write port plus a video byte read port.
  // Reads see the value before any same-clk write.
  always_ff @(posedge clk) begin
    if (pal_cs && !wr_n) begin
      if (cpu_addr[0]) ram_hi[cpu_a] <= cpu_dout;
      else             ram_lo[cpu_a] <= cpu_dout;
    end
    pal_dout <= cpu_addr[0] ? ram_hi[cpu_a] : ram_lo[cpu_a];
    vid_q    <= (state == RD_HI) ? ram_hi[vid_a] : ram_lo[vid_a];
  end

  // Fetch sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A new pixel always (re)starts the fetch; an aborted fetch never reaches DONE.
  always_comb begin
    state_nx = state;
    if (pxl_cen) begin
      state_nx = RD_LO;
    end else begin
      case (state)
        RD_LO:   state_nx = RD_HI;
        RD_HI:   state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Colour word: low byte captured during RD_HI, high byte arrives in DONE.
  always_comb begin
    word_c = {vid_q, lo_byte};
`ifdef JTFRAME_PALMIX_DIM_EN
    fresh_r_c = dim(word_c[3*CW-1 -: CW], bright);
    fresh_g_c = dim(word_c[2*CW-1 -: CW], bright);
    fresh_b_c = dim(word_c[CW-1   -: CW], bright);
`else
    fresh_r_c = dim(word_c[3*CW-1 -: CW]);
    fresh_g_c = dim(word_c[2*CW-1 -: CW]);
    fresh_b_c = dim(word_c[CW-1   -: CW]);
`endif
  end

  // Held colour repeats when the fetch for the last pixel was cut short.
  always_comb begin
    show_r_c = pix_r;
    show_g_c = pix_g;
    show_b_c = pix_b;
    if (state == DONE) begin
      show_r_c = fresh_r_c;
      show_g_c = fresh_g_c;
      show_b_c = fresh_b_c;
    end
  end

  // Pixel pipeline: sample index and blanks, publish previous pixel's colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_a   <= '0;
      lo_byte <= '0;
      pix_r   <= '0;
      pix_g   <= '0;
      pix_b   <= '0;
      lhbl_d  <= 1'b0;
      lvbl_d  <= 1'b0;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
    end else begin
      if (state == RD_HI) lo_byte <= vid_q;
      if (state == DONE) begin
        pix_r <= fresh_r_c;
        pix_g <= fresh_g_c;
        pix_b <= fresh_b_c;
      end
      if (pxl_cen) begin
        vid_a  <= {pal_bank, pick_c};
        lhbl_d <= LHBL;
        lvbl_d <= LVBL;
        if (lhbl_d && lvbl_d) begin
          red   <= show_r_c;
          green <= show_g_c;
          blue  <= show_b_c;
        end else begin
          red   <= '0;
          green <= '0;
          blue  <= '0;
        end
      end
    end
  end

endmodule
